// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-rate enable, h/v counters, sync pulses,
// visible-area window and a frame-start strobe, all registered and mutually aligned.
module vga_sync #(
    parameter int   HD          = 640,
    parameter int   HF          = 16,
    parameter int   HR          = 96,
    parameter int   HB          = 48,
    parameter int   VD          = 480,
    parameter int   VF          = 10,
    parameter int   VR          = 2,
    parameter int   VB          = 33,
    parameter int   CLK_DIV     = 2,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int HT    = HD + HF + HR + HB;
    localparam int VT    = VD + VF + VR + VB;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0]       H_LAST   = 10'(HT - 1);
    localparam logic [9:0]       V_LAST   = 10'(VT - 1);
    localparam logic [9:0]       H_VIS    = 10'(HD);
    localparam logic [9:0]       V_VIS    = 10'(VD);
    localparam logic [9:0]       HS_LO    = 10'(HD + HF);
    localparam logic [9:0]       HS_HI    = 10'(HD + HF + HR - 1);
    localparam logic [9:0]       VS_LO    = 10'(VD + VF);
    localparam logic [9:0]       VS_HI    = 10'(VD + VF + VR - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic             frame_q, frame_d;

    logic             h_wrap, v_wrap;
    logic [9:0]       h_nx, v_nx;

    function automatic logic sync_level(input logic [9:0] cnt,
                                        input logic [9:0] lo,
                                        input logic [9:0] hi);
        return ((cnt >= lo) && (cnt <= hi)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    endfunction

    assign p_tick = (div_q == DIV_LAST);
    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);
    assign h_nx   = h_wrap ? 10'd0 : h_q + 10'd1;
    assign v_nx   = h_wrap ? (v_wrap ? 10'd0 : v_q + 10'd1) : v_q;

    // Registered outputs are decoded from the next counter values so they
    // land on the same edge as the counters they describe.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        h_d     = h_q;
        v_d     = v_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        video_d = video_q;
        frame_d = p_tick && h_wrap && v_wrap;
        if (p_tick) begin
            h_d     = h_nx;
            v_d     = v_nx;
            hsync_d = sync_level(h_nx, HS_LO, HS_HI);
            vsync_d = sync_level(v_nx, VS_LO, VS_HI);
            video_d = (h_nx < H_VIS) && (v_nx < V_VIS);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            video_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            frame_q <= frame_d;
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default 640x480 mode, a CLK_DIV=1 / active-high
// sync variant, and a tiny raster that allows full frames and a mid-frame reset.
module tb_vga_sync;

    logic clk = 1'b0;
    logic rst_a, rst_s;

    logic       def_pt, def_vo, def_hs, def_vs, def_fs;
    logic [9:0] def_x, def_y;
    logic       d1_pt, d1_vo, d1_hs, d1_vs, d1_fs;
    logic [9:0] d1_x, d1_y;
    logic       sm_pt, sm_vo, sm_hs, sm_vs, sm_fs;
    logic [9:0] sm_x, sm_y;

    int n_chk  = 0;
    int n_fail = 0;

    string nm[7] = '{"pt", "fs", "vs", "hs", "vo", "y", "x"};

    always #5 clk = ~clk;

    vga_sync u_def (
        .clk(clk), .reset(rst_a), .p_tick(def_pt), .pix_x(def_x), .pix_y(def_y),
        .video_on(def_vo), .hsync(def_hs), .vsync(def_vs), .frame_start(def_fs)
    );

    vga_sync #(.CLK_DIV(1), .SYNC_ACTIVE(1'b1)) u_d1 (
        .clk(clk), .reset(rst_a), .p_tick(d1_pt), .pix_x(d1_x), .pix_y(d1_y),
        .video_on(d1_vo), .hsync(d1_hs), .vsync(d1_vs), .frame_start(d1_fs)
    );

    // 15 x 8 raster, 3 clk per pixel: one frame is 360 clk
    vga_sync #(.HD(8), .HF(2), .HR(3), .HB(2), .VD(4), .VF(1), .VR(2), .VB(1),
               .CLK_DIV(3), .SYNC_ACTIVE(1'b0)) u_sm (
        .clk(clk), .reset(rst_s), .p_tick(sm_pt), .pix_x(sm_x), .pix_y(sm_y),
        .video_on(sm_vo), .hsync(sm_hs), .vsync(sm_vs), .frame_start(sm_fs)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected {x, y, video_on, hsync, vsync} for pixel index n since reset release.
    function automatic logic [22:0] mdl(input int n, input int hd, input int hf,
                                        input int hr, input int hb, input int vd,
                                        input int vf, input int vr, input int vb,
                                        input logic sa);
        int ht, vt, x, y;
        logic vo, hs, vs;
        ht = hd + hf + hr + hb;
        vt = vd + vf + vr + vb;
        x  = n % ht;
        y  = (n / ht) % vt;
        vo = (n > 0) && (x < hd) && (y < vd);
        hs = (x >= hd + hf && x <= hd + hf + hr - 1) ? sa : ~sa;
        vs = (y >= vd + vf && y <= vd + vf + vr - 1) ? sa : ~sa;
        return {10'(x), 10'(y), vo, hs, vs};
    endfunction

    function automatic logic [6:0] diff(input logic [22:0] got, input logic [22:0] exp,
                                        input logic fs_g, input logic fs_e,
                                        input logic pt_g, input logic pt_e);
        return {got[22:13] != exp[22:13], got[12:3] != exp[12:3],
                got[2] != exp[2], got[1] != exp[1], got[0] != exp[0],
                fs_g != fs_e, pt_g != pt_e};
    endfunction

    task automatic track_main(input int ncyc);
        int e_def[7];
        int e_d1[7];
        int hs_low, hs_hi1, wd0, wd1, w10, w11;
        logic [9:0] prev_def, prev_d1;
        logic [6:0] md, m1;
        hs_low = 0; hs_hi1 = 0; wd0 = 0; wd1 = 0; w10 = 0; w11 = 0;
        prev_def = 10'd0; prev_d1 = 10'd0;
        for (int i = 0; i < 7; i++) begin e_def[i] = 0; e_d1[i] = 0; end
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            md = diff({def_x, def_y, def_vo, def_hs, def_vs},
                      mdl(k / 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
                      def_fs, 1'b0, def_pt, (k % 2) == 1);
            m1 = diff({d1_x, d1_y, d1_vo, d1_hs, d1_vs},
                      mdl(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1),
                      d1_fs, 1'b0, d1_pt, 1'b1);
            for (int i = 0; i < 7; i++) begin
                if (md[i]) e_def[i]++;
                if (m1[i]) e_d1[i]++;
            end
            if (k < 1600 && def_hs == 1'b0) hs_low++;
            if (k < 800 && d1_hs == 1'b1) hs_hi1++;
            if (def_x == 10'd0 && prev_def == 10'd799) begin
                if (wd0 == 0) wd0 = k; else if (wd1 == 0) wd1 = k;
            end
            if (d1_x == 10'd0 && prev_d1 == 10'd799) begin
                if (w10 == 0) w10 = k; else if (w11 == 0) w11 = k;
            end
            prev_def = def_x;
            prev_d1  = d1_x;
        end
        for (int i = 0; i < 7; i++) begin
            check($sformatf("def_%s_errs", nm[i]), e_def[i], 0);
            check($sformatf("d1_%s_errs", nm[i]), e_d1[i], 0);
        end
        check("def_hsync_low_clks", hs_low, 192);
        check("d1_hsync_high_clks", hs_hi1, 96);
        check("def_first_wrap_clk", wd0, 1600);
        check("def_line_period", wd1 - wd0, 1600);
        check("d1_first_wrap_clk", w10, 800);
        check("d1_line_period", w11 - w10, 800);
    endtask

    task automatic track_sm(input int ncyc, input string pfx);
        int e[7];
        int vs_low, pulses, last, sp_err, n;
        logic fs_e;
        logic [6:0] m;
        vs_low = 0; pulses = 0; last = 0; sp_err = 0;
        for (int i = 0; i < 7; i++) e[i] = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            n    = k / 3;
            fs_e = (k % 3 == 0) && (n > 0) && (n % 120 == 0);
            m = diff({sm_x, sm_y, sm_vo, sm_hs, sm_vs},
                     mdl(n, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0),
                     sm_fs, fs_e, sm_pt, (k % 3) == 2);
            for (int i = 0; i < 7; i++) if (m[i]) e[i]++;
            if (k < 360 && sm_vs == 1'b0) vs_low++;
            if (sm_fs) begin
                pulses++;
                if (last > 0 && (k - last) != 360) sp_err++;
                last = k;
            end
        end
        for (int i = 0; i < 7; i++) check($sformatf("%s_%s_errs", pfx, nm[i]), e[i], 0);
        check({pfx, "_vsync_low_clks"}, vs_low, 90);
        check({pfx, "_fs_pulses"}, pulses, ncyc / 360);
        check({pfx, "_fs_spacing_errs"}, sp_err, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, fs_seen;
        rst_a = 1'b1;
        rst_s = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_def_x", def_x, 0);
        check("rst_def_y", def_y, 0);
        check("rst_def_vo", def_vo, 0);
        check("rst_def_hs", def_hs, 1);
        check("rst_def_vs", def_vs, 1);
        check("rst_def_fs", def_fs, 0);
        check("rst_def_pt", def_pt, 0);
        check("rst_d1_hs", d1_hs, 0);
        check("rst_d1_vs", d1_vs, 0);
        rst_a = 1'b0;
        rst_s = 1'b0;
        fork
            track_main(3300);
            track_sm(3300, "sm");
        join

        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            @(negedge clk);
            if (sm_x == 10'd11 && sm_y == 10'd5) found = 1;
        end
        check("sm_reach_x11_y5", found, 1);
        check("pre_rst_sm_hs", sm_hs, 0);
        check("pre_rst_sm_vs", sm_vs, 0);
        #2 rst_s = 1'b1;
        #1;
        check("mid_rst_x", sm_x, 0);
        check("mid_rst_y", sm_y, 0);
        check("mid_rst_vo", sm_vo, 0);
        check("mid_rst_hs", sm_hs, 1);
        check("mid_rst_vs", sm_vs, 1);
        check("mid_rst_fs", sm_fs, 0);
        check("mid_rst_pt", sm_pt, 0);
        fs_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sm_fs || sm_x != 10'd0) fs_seen++;
        end
        check("mid_rst_hold_errs", fs_seen, 0);
        rst_s = 1'b0;
        track_sm(400, "smr");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
